// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port around mem_port_arbiter.
// master = arbiter side, slave = pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADR_W  = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADR_W-1:0]  if_adr;
  logic [DATA_W-1:0] if_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADR_W-1:0]  d_adr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_adr, d_read, d_write, d_adr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, d_rdata, mem_req, mem_we, mem_adr, mem_wdata
  );

  modport slave (
    output if_req, if_adr, d_read, d_write, d_adr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, d_rdata, mem_req, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises MEM-stage data and instruction-fetch accesses onto one variable-latency
// memory port (data first), stalling the pipeline until the current step's accesses finish.
module mem_port_arbiter #(
  parameter int unsigned ADR_W  = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.master bus,
  output logic             pipe_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, D_BUSY, IF_BUSY} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_done_q, d_done_d;
  logic              if_done_q, if_done_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic d_req, d_pend, if_pend;

  assign d_req      = bus.d_read | bus.d_write;
  assign d_pend     = d_req & ~d_done_q;
  assign if_pend    = bus.if_req & ~if_done_q;
  assign pipe_stall = d_pend | if_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_pend)       state_d = D_BUSY;
        else if (if_pend) state_d = IF_BUSY;
      end
      D_BUSY, IF_BUSY: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    d_done_d    = d_done_q;
    if_done_d   = if_done_q;
    unique case (state_q)
      IDLE: begin
        if (d_pend) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_write;
          mem_adr_d   = bus.d_adr;
          mem_wdata_d = bus.d_wdata;
        end else if (if_pend) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_adr_d   = bus.if_adr;
        end
      end
      D_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          // a simultaneous read+write request was issued as a write: no capture
          if (!mem_we_q) d_rdata_d = bus.mem_rdata;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end
      end
      default: mem_req_d = 1'b0;
    endcase
    // pipeline advances on this edge, so the next step's requests are fresh
    if (!pipe_stall) begin
      d_done_d  = 1'b0;
      if_done_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pipe_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      if_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      if_done_q   <= if_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign stall_cnt     = stall_cnt_q;

endmodule
